// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch handshake, writeback port, downstream handshake and decoded payload.
// slave = the decode stage itself, master = whatever surrounds it (fetch/execute/writeback).
interface id_stage_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshakes: a transfer happens on an edge where valid && ready are both 1.
  // The producer holds its payload steady while valid && !ready.
  logic                  i_if_valid;
  logic                  o_id_ready;
  logic [31:0]           i_if_instr;
  logic [DATA_WIDTH-1:0] i_if_pc;
  logic [2:0]            i_imm_sel;

  logic                  i_wb_en;
  logic [4:0]            i_wb_addr;
  logic [DATA_WIDTH-1:0] i_wb_data;

  logic                  i_ex_ready;
  logic                  i_flush;
  logic                  i_ex_mem_read;
  logic [4:0]            i_ex_rd;

  logic                  o_id_valid;
  logic [DATA_WIDTH-1:0] o_id_pc;
  logic [DATA_WIDTH-1:0] o_id_data_1;
  logic [DATA_WIDTH-1:0] o_id_data_2;
  logic [DATA_WIDTH-1:0] o_id_imm;
  logic [4:0]            o_id_rs1;
  logic [4:0]            o_id_rs2;
  logic [4:0]            o_id_rd;
  logic [6:0]            o_ctrl_opcode;
  logic [2:0]            o_ctrl_funct3;
  logic [6:0]            o_ctrl_funct7;

  modport slave (
    input  i_if_valid, i_if_instr, i_if_pc, i_imm_sel,
    input  i_wb_en, i_wb_addr, i_wb_data,
    input  i_ex_ready, i_flush, i_ex_mem_read, i_ex_rd,
    output o_id_ready, o_id_valid, o_id_pc, o_id_data_1, o_id_data_2, o_id_imm,
    output o_id_rs1, o_id_rs2, o_id_rd,
    output o_ctrl_opcode, o_ctrl_funct3, o_ctrl_funct7
  );

  modport master (
    output i_if_valid, i_if_instr, i_if_pc, i_imm_sel,
    output i_wb_en, i_wb_addr, i_wb_data,
    output i_ex_ready, i_flush, i_ex_mem_read, i_ex_rd,
    input  o_id_ready, o_id_valid, o_id_pc, o_id_data_1, o_id_data_2, o_id_imm,
    input  o_id_rs1, o_id_rs2, o_id_rd,
    input  o_ctrl_opcode, o_ctrl_funct3, o_ctrl_funct7
  );
endinterface

// File: rtl/id_stage.sv
// RISC-V instruction decode stage: register file with write-through, immediate generation, 1-deep output slot.
// Optional load-use stall enabled by defining ID_LOAD_USE_HAZARD_EN.
module id_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic     i_clk,
  input  logic     i_reset,
  id_stage_if.slave bus
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [4:0]            rs1, rs2, rd;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] rdata_1, rdata_2;
  logic                  wb_hit;
  logic                  stall;
  logic                  capture;

  assign rs1 = bus.i_if_instr[19:15];
  assign rs2 = bus.i_if_instr[24:20];
  assign rd  = bus.i_if_instr[11:7];

  assign bus.o_ctrl_opcode = bus.i_if_instr[6:0];
  assign bus.o_ctrl_funct3 = bus.i_if_instr[14:12];
  assign bus.o_ctrl_funct7 = bus.i_if_instr[31:25];

  // x0 and out-of-range indices behave as a hard-wired zero for both read and write.
  function automatic logic addr_live(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NUM_REGS);
  endfunction

  assign wb_hit = bus.i_wb_en && addr_live(bus.i_wb_addr);

  always_comb begin
    rdata_1 = '0;
    rdata_2 = '0;
    if (addr_live(rs1)) begin
      rdata_1 = (wb_hit && bus.i_wb_addr == rs1) ? bus.i_wb_data : regs[rs1[IDX_W-1:0]];
    end
    if (addr_live(rs2)) begin
      rdata_2 = (wb_hit && bus.i_wb_addr == rs2) ? bus.i_wb_data : regs[rs2[IDX_W-1:0]];
    end
  end

  always_comb begin
    logic [31:0] in;
    logic [31:0] ext;
    in  = bus.i_if_instr;
    ext = '0;
    case (bus.i_imm_sel)
      3'b000:  ext = {{20{in[31]}}, in[31:20]};
      3'b001:  ext = {{20{in[31]}}, in[31:25], in[11:7]};
      3'b010:  ext = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      3'b011:  ext = {in[31:12], 12'b0};
      3'b100:  ext = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      default: ext = '0;
    endcase
    imm = '0;
    // Formats are 32-bit; wider datapaths keep extending the sign bit.
    for (int i = 0; i < DATA_WIDTH; i++) begin
      imm[i] = (i < 32) ? ext[i] : in[31];
    end
  end

`ifdef ID_LOAD_USE_HAZARD_EN
  // A load in execute cannot forward in time; hold the consumer one cycle. A flush wins.
  assign stall = bus.i_if_valid && bus.i_ex_mem_read && (bus.i_ex_rd != 5'd0) &&
                 ((bus.i_ex_rd == rs1) || (bus.i_ex_rd == rs2)) && !bus.i_flush;
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = &{1'b0, bus.i_ex_mem_read, bus.i_ex_rd};
  assign stall = 1'b0;
`endif

  assign bus.o_id_ready = (!bus.o_id_valid || bus.i_ex_ready) && !stall;
  assign capture        = bus.i_if_valid && bus.o_id_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[bus.i_wb_addr[IDX_W-1:0]] <= bus.i_wb_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_id_valid  <= 1'b0;
      bus.o_id_pc     <= '0;
      bus.o_id_data_1 <= '0;
      bus.o_id_data_2 <= '0;
      bus.o_id_imm    <= '0;
      bus.o_id_rs1    <= '0;
      bus.o_id_rs2    <= '0;
      bus.o_id_rd     <= '0;
    end else if (bus.i_flush) begin
      bus.o_id_valid <= 1'b0;
    end else if (capture) begin
      bus.o_id_valid  <= 1'b1;
      bus.o_id_pc     <= bus.i_if_pc;
      bus.o_id_data_1 <= rdata_1;
      bus.o_id_data_2 <= rdata_2;
      bus.o_id_imm    <= imm;
      bus.o_id_rs1    <= rs1;
      bus.o_id_rs2    <= rs2;
      bus.o_id_rd     <= rd;
    end else if (bus.o_id_valid && bus.i_ex_ready) begin
      bus.o_id_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: immediates, register file and bypass, handshake, flush, load-use, async reset.
module tb_id_stage;
  logic i_clk = 1'b0;
  logic i_reset;
  int   total = 0;
  int   bad   = 0;

  id_stage_if #(.DATA_WIDTH(32)) bus ();

  id_stage #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [2:0] sel);
    bus.i_if_valid = v;
    bus.i_if_instr = instr;
    bus.i_if_pc    = pc;
    bus.i_imm_sel  = sel;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.i_wb_en   = en;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
  endtask

  initial begin
    i_reset           = 1'b1;
    fetch(1'b0, 32'h0, 32'h0, 3'b000);
    wb(1'b0, 5'd0, 32'h0);
    bus.i_ex_ready    = 1'b1;
    bus.i_flush       = 1'b0;
    bus.i_ex_mem_read = 1'b0;
    bus.i_ex_rd       = 5'd0;

    #12;
    chk("rst_valid", bus.o_id_valid, 1'b0);
    chk("rst_ready", bus.o_id_ready, 1'b1);
    chk("rst_data1", bus.o_id_data_1, 32'h0);
    chk("rst_imm",   bus.o_id_imm, 32'h0);
    chk("rst_pc",    bus.o_id_pc, 32'h0);
    chk("rst_rd",    bus.o_id_rd, 5'd0);
    i_reset = 1'b0;

    // immediates
    fetch(1'b1, 32'hFFF00093, 32'h100, 3'b000);
    #1;
    chk("ctrl_opcode_i", bus.o_ctrl_opcode, 7'h13);
    chk("ctrl_funct7_i", bus.o_ctrl_funct7, 7'h7F);
    tick();
    chk("i_valid", bus.o_id_valid, 1'b1);
    chk("i_imm",   bus.o_id_imm, 32'hFFFFFFFF);
    chk("i_rd",    bus.o_id_rd, 5'd1);
    chk("i_pc",    bus.o_id_pc, 32'h100);
    fetch(1'b1, 32'h800000EF, 32'h104, 3'b100);
    tick();
    chk("j_imm", bus.o_id_imm, 32'hFFF00000);
    chk("j_pc",  bus.o_id_pc, 32'h104);
    fetch(1'b1, 32'hFE512E23, 32'h108, 3'b001);
    #1;
    chk("ctrl_opcode_s", bus.o_ctrl_opcode, 7'h23);
    chk("ctrl_funct3_s", bus.o_ctrl_funct3, 3'd2);
    tick();
    chk("s_imm", bus.o_id_imm, 32'hFFFFFFFC);
    chk("s_rs1", bus.o_id_rs1, 5'd2);
    chk("s_rs2", bus.o_id_rs2, 5'd5);
    bus.i_imm_sel = 3'b010;
    tick();
    chk("b_imm", bus.o_id_imm, 32'hFFFFF7FC);
    bus.i_imm_sel = 3'b011;
    tick();
    chk("u_imm", bus.o_id_imm, 32'hFE512000);
    bus.i_imm_sel = 3'b101;
    tick();
    chk("sel5_imm", bus.o_id_imm, 32'h0);
    fetch(1'b1, 32'h00A00093, 32'h10C, 3'b000);
    tick();
    chk("i_pos_imm", bus.o_id_imm, 32'h0000000A);

    // register file, bypass, x0
    fetch(1'b0, 32'h0, 32'h0, 3'b000);
    wb(1'b1, 5'd6, 32'h12345678);
    tick();
    chk("drain_valid", bus.o_id_valid, 1'b0);
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    fetch(1'b1, 32'h006283B3, 32'h110, 3'b000);
    tick();
    chk("byp_data1", bus.o_id_data_1, 32'hDEADBEEF);
    chk("byp_data2", bus.o_id_data_2, 32'h12345678);
    chk("byp_rd",    bus.o_id_rd, 5'd7);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("rf_data1", bus.o_id_data_1, 32'hDEADBEEF);
    wb(1'b1, 5'd0, 32'h7);
    fetch(1'b1, 32'h00000033, 32'h114, 3'b000);
    tick();
    chk("x0_byp_data1", bus.o_id_data_1, 32'h0);
    chk("x0_byp_data2", bus.o_id_data_2, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("x0_rf_data1", bus.o_id_data_1, 32'h0);

    // backpressure
    fetch(1'b1, 32'h00A00093, 32'h200, 3'b000);
    tick();
    chk("bp_first_pc", bus.o_id_pc, 32'h200);
    bus.i_ex_ready = 1'b0;
    fetch(1'b1, 32'hFFF00093, 32'h204, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", bus.o_id_ready, 1'b0);
      tick();
      chk("bp_valid", bus.o_id_valid, 1'b1);
      chk("bp_pc",    bus.o_id_pc, 32'h200);
      chk("bp_imm",   bus.o_id_imm, 32'h0000000A);
    end
    bus.i_ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.o_id_ready, 1'b1);
    tick();
    chk("bp_xfer_pc",  bus.o_id_pc, 32'h204);
    chk("bp_xfer_imm", bus.o_id_imm, 32'hFFFFFFFF);
    bus.i_if_valid = 1'b0;
    tick();
    chk("bp_drain_valid", bus.o_id_valid, 1'b0);

    // flush, with a register write in the same cycle
    fetch(1'b1, 32'h00A00093, 32'h300, 3'b000);
    tick();
    chk("fl_pre_valid", bus.o_id_valid, 1'b1);
    fetch(1'b1, 32'h00A00093, 32'h304, 3'b000);
    bus.i_flush = 1'b1;
    wb(1'b1, 5'd8, 32'h00000055);
    tick();
    chk("fl_valid", bus.o_id_valid, 1'b0);
    bus.i_flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    fetch(1'b1, 32'h00040093, 32'h308, 3'b000);
    tick();
    chk("fl_wb_data1", bus.o_id_data_1, 32'h00000055);
    chk("fl_after_pc", bus.o_id_pc, 32'h308);

    // load-use: rd of a load in execute matches rs2
    bus.i_ex_mem_read = 1'b1;
    bus.i_ex_rd       = 5'd0;
    fetch(1'b1, 32'h00308233, 32'h400, 3'b000);
    #1;
    chk("lu_rd0_ready", bus.o_id_ready, 1'b1);
    bus.i_ex_rd = 5'd3;
    #1;
`ifdef ID_LOAD_USE_HAZARD_EN
    chk("lu_ready", bus.o_id_ready, 1'b0);
    tick();
    chk("lu_bubble", bus.o_id_valid, 1'b0);
    bus.i_ex_mem_read = 1'b0;
    #1;
    chk("lu_resume_ready", bus.o_id_ready, 1'b1);
    tick();
`else
    chk("lu_ready", bus.o_id_ready, 1'b1);
    tick();
`endif
    chk("lu_valid", bus.o_id_valid, 1'b1);
    chk("lu_rd",    bus.o_id_rd, 5'd4);
    chk("lu_pc",    bus.o_id_pc, 32'h400);
    bus.i_ex_mem_read = 1'b0;
    bus.i_ex_rd       = 5'd0;

    // fill x1 and x31, then reset asynchronously between edges
    fetch(1'b0, 32'h0, 32'h0, 3'b000);
    wb(1'b1, 5'd1, 32'h00000011);
    tick();
    wb(1'b1, 5'd31, 32'h000000FF);
    fetch(1'b1, 32'h01F08033, 32'h500, 3'b000);
    tick();
    chk("pre_rst_data1", bus.o_id_data_1, 32'h00000011);
    chk("pre_rst_data2", bus.o_id_data_2, 32'h000000FF);
    chk("pre_rst_valid", bus.o_id_valid, 1'b1);
    wb(1'b0, 5'd0, 32'h0);
    #3;
    i_reset = 1'b1;
    wb(1'b1, 5'd2, 32'h00000099);
    #1;
    chk("async_rst_valid", bus.o_id_valid, 1'b0);
    chk("async_rst_data1", bus.o_id_data_1, 32'h0);
    chk("async_rst_pc",    bus.o_id_pc, 32'h0);
    tick();
    #2;
    i_reset = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++) begin
      logic [4:0]  r;
      logic [31:0] instr;
      r     = 5'(i);
      instr = {7'd0, r, r, 3'd0, 5'd0, 7'h33};
      fetch(1'b1, instr, 32'h600, 3'b000);
      tick();
      chk("post_rst_valid", bus.o_id_valid, 1'b1);
      chk("post_rst_data1", bus.o_id_data_1, 32'h0);
      chk("post_rst_data2", bus.o_id_data_2, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
